// File: rtl/stub_frame_receiver.sv
// rtl/stub_frame_receiver.sv - stub FIFO, byte-serial frame emitter and config register file
// Define STUB_FRAME_CKSUM_EN to append an XOR checksum byte to every frame.
module stub_frame_receiver #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_LAYERS  = 6,
  parameter int NLAYERS_RST = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in_x,
  input  logic [DATA_W-1:0] data_in_y,
  input  logic [DATA_W-1:0] data_in_z,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        mem_add,
  input  logic              mem_en,
  input  logic              mem_rd_wr,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out,
  output logic              ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = 3 * DATA_W;
  localparam logic [AW:0]       DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] MAXL_D  = DATA_W'(MAX_LAYERS);
  localparam logic [2:0]        MAXL_3  = 3'(MAX_LAYERS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT
`ifdef STUB_FRAME_CKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_level;
  logic [2:0]        r_nlayers, r_stub_left;
  logic [1:0]        r_byte_sel;
  logic              r_enable, r_overflow;
  logic [DATA_W-1:0] r_fcount;
`ifdef STUB_FRAME_CKSUM_EN
  logic [DATA_W-1:0] r_cksum;
`endif

  logic              w_wr, w_flush, w_full, w_empty, w_push, w_ovf_set;
  logic              w_start, w_emit, w_pop, w_frame_done;
  logic [DATA_W-1:0] w_byte, w_rd_val;
  logic [SW-1:0]     w_head;
  logic [AW:0]       w_nl_ext;
  logic [2:0]        w_nl_wdata;

  assign w_wr       = mem_en && mem_rd_wr;
  assign w_flush    = w_wr && (mem_add == 2'd1) && mem_data[1];
  assign w_full     = (r_level == DEPTH_L);
  assign w_empty    = (r_level == '0);
  assign w_push     = data_valid && r_enable && !w_full;
  assign w_ovf_set  = data_valid && r_enable && w_full;
  assign w_head     = r_mem[r_rptr];
  assign w_nl_ext   = {{(AW-2){1'b0}}, r_nlayers};
  assign w_nl_wdata = ((mem_data == '0) || (mem_data > MAXL_D)) ? MAXL_3 : mem_data[2:0];

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_emit       = 1'b0;
    w_pop        = 1'b0;
    w_frame_done = 1'b0;
    w_byte       = '0;
    case (r_state)
      S_IDLE: begin
        if (r_level >= w_nl_ext) begin
          w_state_nxt = S_EMIT;
          w_start     = 1'b1;
        end
      end
      S_EMIT: begin
        w_emit = 1'b1;
        case (r_byte_sel)
          2'd0:    w_byte = w_head[SW-1 -: DATA_W];
          2'd1:    w_byte = w_head[2*DATA_W-1 -: DATA_W];
          default: begin
            w_byte = w_head[DATA_W-1:0];
            w_pop  = 1'b1;
          end
        endcase
        if (w_pop && (r_stub_left == 3'd1)) begin
`ifdef STUB_FRAME_CKSUM_EN
          w_state_nxt = S_CKSUM;
`else
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
`endif
        end
      end
`ifdef STUB_FRAME_CKSUM_EN
      S_CKSUM: begin
        w_emit       = 1'b1;
        w_byte       = r_cksum;
        w_frame_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    // A flush overrides everything the frame would have done this cycle.
    if (w_flush) begin
      w_state_nxt  = S_IDLE;
      w_start      = 1'b0;
      w_emit       = 1'b0;
      w_pop        = 1'b0;
      w_frame_done = 1'b0;
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (mem_add)
      2'd0:    w_rd_val[2:0] = r_nlayers;
      2'd1:    w_rd_val[0]   = r_enable;
      2'd2:    w_rd_val      = r_fcount;
      default: w_rd_val[2:0] = {w_full, w_empty, r_overflow};
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= {data_in_x, data_in_y, data_in_z};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_nlayers   <= 3'(NLAYERS_RST);
      r_stub_left <= '0;
      r_byte_sel  <= '0;
      r_enable    <= 1'b1;
      r_overflow  <= 1'b0;
      r_fcount    <= '0;
`ifdef STUB_FRAME_CKSUM_EN
      r_cksum     <= '0;
`endif
      data_out    <= '0;
      ready       <= 1'b0;
      mem_rdata   <= '0;
    end else begin
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)      r_level <= r_level + 1'b1;
        else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      end

      if (w_start) begin
        r_stub_left <= r_nlayers;
        r_byte_sel  <= '0;
`ifdef STUB_FRAME_CKSUM_EN
        r_cksum     <= '0;
`endif
      end else if (w_emit && (r_state == S_EMIT)) begin
        r_byte_sel <= (r_byte_sel == 2'd2) ? 2'd0 : r_byte_sel + 2'd1;
        if (w_pop) r_stub_left <= r_stub_left - 3'd1;
`ifdef STUB_FRAME_CKSUM_EN
        r_cksum <= r_cksum ^ w_byte;
`endif
      end

      ready <= w_emit;
      if (w_emit)       data_out <= w_byte;
      if (w_frame_done) r_fcount <= r_fcount + 1'b1;

      if (w_wr && (mem_add == 2'd0)) r_nlayers <= w_nl_wdata;
      if (w_wr && (mem_add == 2'd1)) r_enable  <= mem_data[0];
      if (w_ovf_set)                                        r_overflow <= 1'b1;
      else if (w_wr && (mem_add == 2'd3) && mem_data[0])    r_overflow <= 1'b0;

      if (mem_en && !mem_rd_wr) mem_rdata <= w_rd_val;
    end
  end
endmodule

// File: tb/tb_stub_frame_receiver.sv
// tb/tb_stub_frame_receiver.sv - randomized self-checking bench with a queue-based reference model
`timescale 1ns/1ps
module tb_stub_frame_receiver;
  logic       clock = 1'b0;
  logic       reset;
  logic       data_valid;
  logic [7:0] data_in_x, data_in_y, data_in_z;
  logic [7:0] mem_data;
  logic [1:0] mem_add;
  logic       mem_en, mem_rd_wr;
  logic [7:0] mem_rdata, data_out;
  logic       ready;

  always #5 clock = ~clock;

  stub_frame_receiver dut (
    .clock(clock), .reset(reset), .data_valid(data_valid),
    .data_in_x(data_in_x), .data_in_y(data_in_y), .data_in_z(data_in_z),
    .mem_data(mem_data), .mem_add(mem_add), .mem_en(mem_en), .mem_rd_wr(mem_rd_wr),
    .mem_rdata(mem_rdata), .data_out(data_out), .ready(ready)
  );

`ifdef STUB_FRAME_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // Reference model: stub queue plus the byte list of the frame in flight.
  logic [23:0] m_fifo[$];
  logic [7:0]  m_exp[$];
  int          m_pos, m_nl, m_lat;
  bit          m_armed, m_en, m_ovf, m_ready;
  logic [7:0]  m_fc, m_dout, m_rdata;
  bit          e_ready;
  logic [7:0]  e_dout, e_rdata;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction

  function automatic logic [7:0] reg_val(logic [1:0] a);
    case (a)
      2'd0:    return 8'(m_nl);
      2'd1:    return {7'd0, m_en};
      2'd2:    return m_fc;
      default: return {5'd0, m_fifo.size() == 16, m_fifo.size() == 0, m_ovf};
    endcase
  endfunction

  task automatic emit_next();
    m_dout  = m_exp.pop_front();
    m_ready = 1;
    if ((m_pos % 3 == 2) && (m_pos < 3 * m_lat)) m_fifo.delete(0);
    m_pos++;
    if (m_exp.size() == 0) m_fc++;
  endtask

  task automatic model_step();
    logic [7:0] cks, v;
    bit full, wr, flush, ovf_set;
    if (!reset) begin
      m_fifo.delete(); m_exp.delete();
      m_armed = 0; m_nl = 6; m_en = 1; m_ovf = 0; m_fc = 0;
      m_dout = 0; m_ready = 0; m_rdata = 0;
      return;
    end
    full    = (m_fifo.size() == 16);
    wr      = mem_en && mem_rd_wr;
    flush   = wr && (mem_add == 2'd1) && mem_data[1];
    ovf_set = data_valid && m_en && full;
    if (mem_en && !mem_rd_wr) m_rdata = reg_val(mem_add);
    if (flush) begin
      m_exp.delete(); m_fifo.delete(); m_armed = 0; m_ready = 0;
    end else if (m_exp.size() > 0) begin
      emit_next();
    end else if (m_armed) begin
      m_pos = 0; cks = 0;
      for (int i = 0; i < m_lat; i++)
        for (int b = 2; b >= 0; b--) begin
          v = 8'(m_fifo[i] >> (8 * b));
          m_exp.push_back(v);
          cks ^= v;
        end
      if (CK != 0) m_exp.push_back(cks);
      m_armed = 0;
      emit_next();
    end else begin
      m_ready = 0;
      if (m_fifo.size() >= m_nl) begin m_armed = 1; m_lat = m_nl; end
    end
    if (data_valid && m_en && !full && !flush) m_fifo.push_back({data_in_x, data_in_y, data_in_z});
    if (wr) begin
      case (mem_add)
        2'd0: m_nl = ((mem_data == 0) || (mem_data > 6)) ? 6 : int'(mem_data);
        2'd1: m_en = mem_data[0];
        2'd3: if (mem_data[0]) m_ovf = 0;
        default: ;
      endcase
    end
    if (ovf_set) m_ovf = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    e_ready = m_ready; e_dout = m_dout; e_rdata = m_rdata;
    #1;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("ready", ready, e_ready);
      chk("data_out", data_out, e_dout);
      chk("mem_rdata", mem_rdata, e_rdata);
    end
  end

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    mem_en = 1; mem_rd_wr = 1; mem_add = a; mem_data = d;
    tick();
    mem_en = 0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [7:0] d);
    mem_en = 1; mem_rd_wr = 0; mem_add = a;
    tick();
    mem_en = 0;
    d = mem_rdata;
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    data_valid = 1; data_in_x = x; data_in_y = y; data_in_z = z;
    tick();
    data_valid = 0;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!ready && n < 12) begin tick(); n++; end
    chk(nm, ready, 1);
  endtask

  logic [7:0] v;
  logic [7:0] got[$];
  logic [7:0] want[$];
  bit         rr[$];
  int         runs[$];
  int         cur, rdy_cnt;

  initial begin
    reset = 0; data_valid = 0; data_in_x = 0; data_in_y = 0; data_in_z = 0;
    mem_data = 0; mem_add = 0; mem_en = 0; mem_rd_wr = 0;
    tick(); tick();
    chk_en = 1;
    chk("rst_ready", ready, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    reset = 1;
    tick();

    // Two-layer frame with known bytes and latency.
    reg_wr(2'd0, 8'd2);
    push(8'd1, 8'd2, 8'd3);
    push(8'd4, 8'd5, 8'd6);
    for (int j = 0; j < 12; j++) begin
      tick();
      rr.push_back(ready);
      if (ready) got.push_back(data_out);
    end
    chk("lat_gap_cycle", rr[0], 0);
    chk("lat_first_ready", rr[1], 1);
    for (int j = 1; j <= 6; j++) want.push_back(8'(j));
    if (CK != 0) want.push_back(8'h07);
    chk("t1_len", got.size(), want.size());
    foreach (want[j]) chk("t1_byte", (j < got.size()) ? got[j] : 8'hFF, want[j]);
    reg_rd(2'd2, v); chk("t1_frame_count", v, 1);

    // NLAYERS clamping.
    reg_wr(2'd0, 8'd0); reg_rd(2'd0, v); chk("nl_write0", v, 6);
    reg_wr(2'd0, 8'd7); reg_rd(2'd0, v); chk("nl_write7", v, 6);
    reg_wr(2'd0, 8'd5); reg_rd(2'd0, v); chk("nl_write5", v, 5);
    reg_wr(2'd0, 8'd6);

    // 17 back-to-back stubs while draining: nothing dropped.
    for (int j = 0; j < 17; j++) push(8'($urandom), 8'($urandom), 8'($urandom));
    repeat (60) tick();
    reg_rd(2'd3, v); chk("t3_status", v, 8'h00);
    reg_rd(2'd2, v); chk("t3_frame_count", v, 3);
    reg_wr(2'd1, 8'h03);
    reg_rd(2'd3, v); chk("t3_flushed", v, 8'h02);

    // 22 back-to-back stubs: pushes 21 and 22 hit a full FIFO.
    for (int i = 1; i <= 23; i++) begin
      data_valid = (i <= 22);
      data_in_x = 8'($urandom); data_in_y = 8'($urandom); data_in_z = 8'($urandom);
      mem_en = (i == 21) || (i == 23); mem_rd_wr = 0; mem_add = 2'd3;
      tick();
      if (i == 21) chk("t4_full_no_ovf", mem_rdata, 8'h04);
      if (i == 23) chk("t4_ovf_set", mem_rdata, 8'h01);
    end
    data_valid = 0; mem_en = 0;
    reg_wr(2'd3, 8'h01);
    reg_rd(2'd3, v); chk("t4_ovf_cleared", v[0], 0);
    repeat (70) tick();
    reg_rd(2'd2, v); chk("t4_frame_count", v, 6);
    reg_wr(2'd1, 8'h03);

    // NLAYERS change mid-frame applies to the next frame only.
    rr.delete();
    for (int i = 0; i < 70; i++) begin
      data_valid = (i < 6) || (i >= 10 && i < 13);
      data_in_x = 8'($urandom); data_in_y = 8'($urandom); data_in_z = 8'($urandom);
      mem_en = (i == 8); mem_rd_wr = 1; mem_add = 2'd0; mem_data = 8'd3;
      tick();
      rr.push_back(ready);
    end
    data_valid = 0; mem_en = 0;
    cur = 0;
    foreach (rr[j]) begin
      if (rr[j]) cur++;
      else if (cur > 0) begin runs.push_back(cur); cur = 0; end
    end
    chk("t5_runs", runs.size(), 2);
    chk("t5_frame6_len", (runs.size() > 0) ? runs[0] : 0, 18 + CK);
    chk("t5_frame3_len", (runs.size() > 1) ? runs[1] : 0, 9 + CK);
    reg_rd(2'd2, v); chk("t5_frame_count", v, 8);

    // ENABLE = 0 ignores stubs.
    reg_wr(2'd1, 8'h00);
    rdy_cnt = 0;
    for (int j = 0; j < 5; j++) begin push(8'd9, 8'd9, 8'd9); tick(); rdy_cnt += int'(ready); end
    reg_rd(2'd3, v); chk("t6_status_empty", v, 8'h02);
    chk("t6_no_output", rdy_cnt, 0);
    reg_wr(2'd1, 8'h01);

    // FLUSH mid-frame.
    for (int j = 0; j < 3; j++) push(8'($urandom), 8'($urandom), 8'($urandom));
    wait_ready("t7_started");
    tick();
    reg_wr(2'd1, 8'h03);
    chk("t7_flush_ready", ready, 0);
    reg_rd(2'd3, v); chk("t7_status_empty", v, 8'h02);
    reg_rd(2'd2, v); chk("t7_frame_count", v, 8);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      data_valid = ($urandom_range(0, 9) < 5);
      data_in_x = 8'($urandom); data_in_y = 8'($urandom); data_in_z = 8'($urandom);
      mem_en = ($urandom_range(0, 5) == 0);
      mem_rd_wr = 1'($urandom_range(0, 1));
      mem_add = 2'($urandom_range(0, 3));
      if (mem_add == 2'd1)      mem_data = {6'd0, $urandom_range(0, 20) == 0, $urandom_range(0, 7) != 0};
      else if (mem_add == 2'd0) mem_data = 8'($urandom_range(0, 9));
      else                      mem_data = 8'($urandom);
      tick();
    end
    data_valid = 0; mem_en = 0;

    // Reset mid-frame.
    reg_wr(2'd1, 8'h03);
    reg_wr(2'd0, 8'd3);
    for (int j = 0; j < 3; j++) push(8'($urandom), 8'($urandom), 8'($urandom));
    wait_ready("t8_started");
    tick();
    reset = 0;
    tick();
    chk("t8_rst_ready", ready, 0);
    chk("t8_rst_data_out", data_out, 0);
    reset = 1;
    reg_rd(2'd0, v); chk("t8_nlayers", v, 6);
    reg_rd(2'd1, v); chk("t8_ctrl", v, 1);
    reg_rd(2'd2, v); chk("t8_frame_count", v, 0);
    reg_rd(2'd3, v); chk("t8_status", v, 8'h02);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stub_frame_receiver.md
# stub_frame_receiver

Receiving end of the stub-input, memory-config and output interfaces. Accepts per-layer stubs (x, y, z bytes) and buffers them in a stub FIFO. Once a full track candidate of NLAYERS stubs is stored, it serializes it byte-by-byte onto data_out, with ready as the byte strobe. A small register file is written and read over the memory port for configuration and status.

## Interface
- DATA_W, 8, width of each coordinate and of output/config bytes
- FIFO_DEPTH, 16, stub FIFO depth in stubs; power of two, ≥ MAX_LAYERS
- MAX_LAYERS, 6, largest legal NLAYERS
- NLAYERS_RST, 6, reset value of NLAYERS register

- clock  input  1  sole clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- data_valid  input  1  stub present on data_in_x/y/z this cycle
- data_in_x  input  DATA_W  stub x coordinate
- data_in_y  input  DATA_W  stub y coordinate
- data_in_z  input  DATA_W  stub z coordinate
- mem_data  input  DATA_W  config write data
- mem_add  input  2  register address
- mem_en  input  1  register access strobe
- mem_rd_wr  input  1  1 = write, 0 = read
- mem_rdata  output  DATA_W  register read data
- data_out  output  DATA_W  serialized frame byte
- ready  output  1  data_out holds a valid byte this cycle

## Operation
- Register map (mem_add):
  - 0 NLAYERS: bits 2:0; reset NLAYERS_RST; writes of 0 or > MAX_LAYERS store MAX_LAYERS.
  - 1 CTRL: bit0 ENABLE (reset 1; when 0, data_valid is ignored); bit1 FLUSH (write 1 empties FIFO and aborts any frame; self-clears, always reads 0).
  - 2 FRAME_COUNT: frames completed; read-only; wraps 255→0.
  - 3 STATUS: bit0 OVERFLOW (sticky; write 1 clears), bit1 FIFO empty, bit2 FIFO full; other bits read 0.
- Stub push: when data_valid && ENABLE && !full, {x,y,z} is written to the FIFO.
- Overflow: data_valid && ENABLE && full drops the stub and sets OVERFLOW. A pop on the same cycle does not rescue the stub; full is evaluated before the pop.
- FSM states:
  - IDLE: enters EMIT when FIFO level ≥ NLAYERS. The NLAYERS value is latched into a frame counter on this transition.
  - EMIT: per stub, emits x, then y, then z, one byte per cycle. The stub is popped in the cycle z is driven. After the last stub's z, goes to CKSUM (if compiled in) or IDLE.
  - CKSUM: emits one checksum byte, then goes to IDLE.
- No backpressure: once started, a frame streams one byte per cycle without gaps.
- Push and pop in the same cycle are legal; the level is unchanged.
- FRAME_COUNT increments on the cycle the last frame byte is driven.
- NLAYERS writes take effect from the next frame start only. A frame in progress uses the latched value.
- FLUSH mid-frame: ready drops on the next cycle, FIFO level becomes 0, FSM goes to IDLE. FRAME_COUNT is not incremented.
- Register read: mem_en && !mem_rd_wr at edge k gives mem_rdata valid after edge k, held until the next read. Reads have no side effects.

## Timing
- All outputs are registered.
- Reset values:
  - data_out = 0, ready = 0, mem_rdata = 0
  - FIFO empty, FSM IDLE, FRAME_COUNT = 0, OVERFLOW = 0, ENABLE = 1
- Reset asserted mid-frame: outputs return to reset values after the next edge.
- Latency: a stub sampled at edge k that brings the level to NLAYERS produces ready = 1 with the first x byte after edge k+2.
- Frame length: 3·NLAYERS bytes, plus 1 if the checksum is compiled in.
- Back-to-back frames: if the level is still ≥ NLAYERS when the FSM returns to IDLE, the next frame starts with one idle cycle (ready = 0) between frames.
- While idle, data_out holds its last value and ready = 0.

## Configuration
- STUB_FRAME_CKSUM_EN defined: each frame is followed by one byte equal to the XOR of all 3·NLAYERS frame bytes, with ready = 1.
- STUB_FRAME_CKSUM_EN undefined: no CKSUM state; the frame ends after the last z byte.

## Test plan
- Reset, NLAYERS = 2; push stubs (1,2,3), (4,5,6) → ready for 6 cycles with data_out 1,2,3,4,5,6. With the checksum macro, a 7th byte 0x07 follows. FRAME_COUNT reads 1.
- Push 17 stubs back-to-back with NLAYERS = 6 while the FSM drains → no stub lost. Exactly the dropped count matches 17 − 16 − pops; verify OVERFLOW sets only when a push hits full, and clears on write 1 to addr 3.
- Write NLAYERS = 3 during a 6-layer frame → current frame is 18 bytes; the next frame is 9 bytes.
- Write NLAYERS = 0 → reads back 6; write NLAYERS = 7 → reads back 6.
- CTRL.ENABLE = 0 with data_valid pulses → STATUS bit1 = 1 and no output. Write FLUSH mid-frame → ready = 0 the next cycle and FIFO empty.
- Assert reset mid-frame → ready = 0, all registers read their reset values, FRAME_COUNT = 0.
